mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Parametrised memory-access stage of the five-stage CPU pipeline, sitting between EX and WB. Non-memory instructions pass straight through to a registered WB interface. Loads and stores run a request/response transaction on the data bus with byte-lane steering, sign/zero extension and a misalignment check. The stage stalls upstream while a transaction is outstanding.

## Interface
- DATA_WIDTH, 32: data path width in bits; 32 or 64.
- ADDR_WIDTH, 32: address width in bits.
- REG_ADDR_WIDTH, 5: register-file address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- valid_in  in  1  EX presents a valid instruction.
- result_in  in  DATA_WIDTH  ALU result, or effective address when mem_en_in=1 (low ADDR_WIDTH bits used).
- write_reg_en_in  in  1  instruction writes the register file.
- write_reg_addr_in  in  REG_ADDR_WIDTH  destination register.
- mem_en_in  in  1  instruction is a load or store.
- mem_we_in  in  1  1=store, 0=load.
- mem_size_in  in  2  0=byte, 1=half, 2=full DATA_WIDTH word, 3=reserved (treated as misaligned).
- mem_unsigned_in  in  1  zero-extend load (LBU/LHU).
- store_data_in  in  DATA_WIDTH  store data, right-aligned.
- stall_out  out  1  EX must hold all inputs stable this cycle.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_WIDTH  address with the low log2(DATA_WIDTH/8) bits forced to 0.
- mem_be  out  DATA_WIDTH/8  byte enables.
- mem_wdata  out  DATA_WIDTH  lane-steered store data.
- mem_gnt  in  1  bus accepts the request this cycle.
- mem_rvalid  in  1  response or store acknowledge.
- mem_rdata  in  DATA_WIDTH  read data (full bus word).
- valid_out  out  1  registered: WB holds a valid instruction.
- result_out  out  DATA_WIDTH  registered result.
- write_reg_en_out  out  1  registered write enable.
- write_reg_addr_out  out  REG_ADDR_WIDTH  registered destination register.
- addr_err_out  out  1  registered one-cycle misalignment flag.

## Operation
- FSM states: IDLE, WAIT.
- Byte offset off = low log2(DATA_WIDTH/8) bits of the address.
- Access size in bytes: n = 1, 2 or DATA_WIDTH/8.
- Misaligned when size=3, or when off is not a multiple of n.
- mem_be = ((1<<n)-1) << off.
- mem_wdata = store_data_in << (8*off).
- Load data is mem_rdata >> (8*off), truncated to n bytes, then sign-extended (mem_unsigned_in=0) or zero-extended to DATA_WIDTH. Size 2 is unextended.
- IDLE, valid_in=0: WB registers load a bubble.
  - Bubble: valid_out=0, write_reg_en_out=0, result_out=0, addr_err_out=0.
- IDLE, valid non-memory instruction:
  - WB registers load result_in, write_reg_en_in, write_reg_addr_in, with valid_out=1.
  - stall_out=0.
- IDLE, valid memory op, misaligned:
  - No request is issued; stall_out=0.
  - WB registers load valid_out=1, write_reg_en_out=0, result_out=result_in, addr_err_out=1.
- IDLE, valid aligned memory op:
  - mem_req=1 combinationally from the inputs; stall_out=1.
  - mem_gnt=1: go to WAIT. mem_gnt=0: stay in IDLE and keep requesting.
  - WB registers load a bubble.
- WAIT:
  - mem_req=0; rvalid is ignored in IDLE.
  - mem_rvalid=0: stall_out=1, WB registers load a bubble.
  - mem_rvalid=1: stall_out=0 and return to IDLE.
    - Load: WB registers load the extended data with write_reg_en_in and write_reg_addr_in.
    - Store: WB registers load result_in with write_reg_en_out=0.
- The offset, size and signedness used for extension come from the held EX inputs.
- mem_we, mem_addr, mem_be and mem_wdata are 0 whenever mem_req=0.

## Timing
- Reset (rst=0, async): state=IDLE and all registered outputs 0. stall_out and the mem_* outputs follow from IDLE with valid_in gated to 0, so they are all 0.
- Reset mid-transaction: the transaction is abandoned. A late mem_rvalid after reset release is ignored because the FSM is in IDLE.
- Non-memory latency: 1 cycle, i.e. the instruction is visible on the WB outputs after the next edge.
- Memory-op latency: minimum 2 cycles (gnt in cycle 0, rvalid in cycle 1, WB outputs valid after the cycle-1 edge). Each cycle gnt or rvalid is late adds 1.
- Back-to-back memory ops: a new request may be issued in the cycle after the rvalid cycle, with no dead cycle beyond that.
- addr_err_out is high for exactly one cycle per misaligned instruction.

## Test plan
- Reset: hold rst=0 while driving random inputs. All registered outputs stay 0, state stays IDLE, and mem_req=0.
- ALU pass-through: valid non-memory instruction, result=0x1234_5678, reg 5, wen=1. Next cycle valid_out=1, result_out=0x12345678, write_reg_addr_out=5, and stall_out is never raised.
- Sign/zero extension, DATA_WIDTH=32, address 0x1003 with byte lane 3 returning 0x80:
  - LB gives 0xFFFF_FF80 and LBU gives 0x0000_0080.
  - mem_be=4'b1000 and mem_addr=0x1000.
  - Bus: gnt delayed 2 cycles, rvalid delayed 3 cycles. stall_out stays high throughout.
- Store half at 0x2002, data 0xABCD:
  - mem_we=1, mem_be=4'b1100, mem_wdata=0xABCD_0000.
  - After rvalid, valid_out=1 and write_reg_en_out=0.
- Misaligned: LW at 0x3001, and a half access at offset 1. For each: mem_req never rises, addr_err_out=1 for one cycle, and write_reg_en_out=0.
- Reset in WAIT: assert rst while in WAIT, then release and pulse mem_rvalid. There is no WB write, and a following ALU instruction completes normally.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - data bus interface between the memory stage and the data memory
//
// Purpose: groups the request/response data-bus signals of the memory stage.
// Ports (signals):
//   mem_req    - bus request (master -> slave)
//   mem_we     - bus write   (master -> slave)
//   mem_addr   - word-aligned address (master -> slave)
//   mem_be     - byte enables (master -> slave)
//   mem_wdata  - lane-steered store data (master -> slave)
//   mem_gnt    - request accepted this cycle (slave -> master)
//   mem_rvalid - read response / store acknowledge (slave -> master)
//   mem_rdata  - full bus read word (slave -> master)
interface mem_stage_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - pipeline memory-access stage between EX and WB
//
// Purpose: passes ALU results through to registered WB outputs; runs load/store
// transactions on the data bus with byte-lane steering, sign/zero extension and
// a misalignment check; stalls EX while a transaction is outstanding.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   valid_in .. store_data_in - instruction fields presented by EX
//   stall_out           - EX must hold its inputs this cycle
//   bus                 - data bus (master side)
//   valid_out .. addr_err_out - registered WB outputs
module mem_stage_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [DATA_WIDTH-1:0]     result_in,
  input  logic                      write_reg_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] write_reg_addr_in,
  input  logic                      mem_en_in,
  input  logic                      mem_we_in,
  input  logic [1:0]                mem_size_in,
  input  logic                      mem_unsigned_in,
  input  logic [DATA_WIDTH-1:0]     store_data_in,
  output logic                      stall_out,
  mem_stage_lsu_if.master           bus,
  output logic                      valid_out,
  output logic [DATA_WIDTH-1:0]     result_out,
  output logic                      write_reg_en_out,
  output logic [REG_ADDR_WIDTH-1:0] write_reg_addr_out,
  output logic                      addr_err_out
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state_q, state_d;

  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic                      wen_q, wen_d;
  logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                      err_q, err_d;

  // While reset is held the instruction is treated as absent, so stall_out
  // and the bus outputs collapse to their idle values.
  logic valid_g;
  assign valid_g = valid_in & rst;

  logic [OFF_W-1:0] off;
  logic [OFF_W+2:0] bit_sh;
  assign off    = result_in[OFF_W-1:0];
  assign bit_sh = {off, 3'b000};

  logic misaligned;
  always_comb begin
    case (mem_size_in)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = (off != '0);
      default: misaligned = 1'b1;
    endcase
  end

  logic [NB-1:0] be_base;
  logic [NB-1:0] be_lane;
  always_comb begin
    case (mem_size_in)
      2'd0:    be_base = NB'(1);
      2'd1:    be_base = NB'(3);
      default: be_base = '1;
    endcase
  end
  assign be_lane = be_base << off;

  logic [DATA_WIDTH-1:0] wdata_lane;
  assign wdata_lane = store_data_in << bit_sh;

  logic [ADDR_WIDTH-1:0] addr_full;
  logic [ADDR_WIDTH-1:0] addr_word;
  assign addr_full = ADDR_WIDTH'(result_in);
  assign addr_word = addr_full & ~ADDR_WIDTH'(NB - 1);

  // Response extension relies on EX holding the instruction during WAIT.
  logic [DATA_WIDTH-1:0] rdata_sh;
  logic [DATA_WIDTH-1:0] load_data;
  assign rdata_sh = bus.mem_rdata >> bit_sh;
  always_comb begin
    case (mem_size_in)
      2'd0:    load_data = {{(DATA_WIDTH-8){~mem_unsigned_in & rdata_sh[7]}}, rdata_sh[7:0]};
      2'd1:    load_data = {{(DATA_WIDTH-16){~mem_unsigned_in & rdata_sh[15]}}, rdata_sh[15:0]};
      default: load_data = rdata_sh;
    endcase
  end

  logic req;

  always_comb begin
    state_d   = state_q;
    stall_out = 1'b0;
    req       = 1'b0;
    valid_d   = 1'b0;
    result_d  = '0;
    wen_d     = 1'b0;
    waddr_d   = '0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_g) begin
          if (!mem_en_in) begin
            valid_d  = 1'b1;
            result_d = result_in;
            wen_d    = write_reg_en_in;
            waddr_d  = write_reg_addr_in;
          end else if (misaligned) begin
            valid_d  = 1'b1;
            result_d = result_in;
            waddr_d  = write_reg_addr_in;
            err_d    = 1'b1;
          end else begin
            req       = 1'b1;
            stall_out = 1'b1;
            if (bus.mem_gnt) begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = IDLE;
          valid_d = 1'b1;
          waddr_d = write_reg_addr_in;
          if (mem_we_in) begin
            result_d = result_in;
          end else begin
            result_d = load_data;
            wen_d    = write_reg_en_in;
          end
        end else begin
          stall_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req   = req;
  assign bus.mem_we    = req & mem_we_in;
  assign bus.mem_addr  = req ? addr_word : '0;
  assign bus.mem_be    = req ? be_lane : '0;
  assign bus.mem_wdata = req ? wdata_lane : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      err_q    <= err_d;
    end
  end

  assign valid_out          = valid_q;
  assign result_out         = result_q;
  assign write_reg_en_out   = wen_q;
  assign write_reg_addr_out = waddr_q;
  assign addr_err_out       = err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard testbench for mem_stage_lsu
module tb_mem_stage_lsu;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] result_in = '0;
  logic          write_reg_en_in = 1'b0;
  logic [RW-1:0] write_reg_addr_in = '0;
  logic          mem_en_in = 1'b0;
  logic          mem_we_in = 1'b0;
  logic [1:0]    mem_size_in = '0;
  logic          mem_unsigned_in = 1'b0;
  logic [DW-1:0] store_data_in = '0;
  logic          stall_out;
  logic          valid_out;
  logic [DW-1:0] result_out;
  logic          write_reg_en_out;
  logic [RW-1:0] write_reg_addr_out;
  logic          addr_err_out;

  always #5 clk = ~clk;

  mem_stage_lsu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_stage_lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_in          (valid_in),
    .result_in         (result_in),
    .write_reg_en_in   (write_reg_en_in),
    .write_reg_addr_in (write_reg_addr_in),
    .mem_en_in         (mem_en_in),
    .mem_we_in         (mem_we_in),
    .mem_size_in       (mem_size_in),
    .mem_unsigned_in   (mem_unsigned_in),
    .store_data_in     (store_data_in),
    .stall_out         (stall_out),
    .bus               (bus.master),
    .valid_out         (valid_out),
    .result_out        (result_out),
    .write_reg_en_out  (write_reg_en_out),
    .write_reg_addr_out(write_reg_addr_out),
    .addr_err_out      (addr_err_out)
  );

  typedef struct {
    logic [DW-1:0] result;
    logic          wen;
    logic [RW-1:0] waddr;
    logic          err;
  } wb_t;

  wb_t   exp_q[$];
  wb_t   mon_e;
  int    checks = 0;
  int    errors = 0;
  string cur = "reset";

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur, name, act, exp);
    end
  endtask

  // Monitor: every WB-valid cycle consumes one expected entry.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s/unexpected_wb: got result 0x%0h expected no writeback", cur, result_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_result", result_out, mon_e.result);
        chk("wb_wen", DW'(write_reg_en_out), DW'(mon_e.wen));
        chk("wb_err", DW'(addr_err_out), DW'(mon_e.err));
        if (mon_e.wen) chk("wb_waddr", DW'(write_reg_addr_out), DW'(mon_e.waddr));
      end
    end else begin
      chk("bubble_wen", DW'(write_reg_en_out), '0);
      chk("bubble_err", DW'(addr_err_out), '0);
      chk("bubble_result", result_out, '0);
    end
  end

  task automatic set_ex(input logic memen, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [DW-1:0] res, input logic [DW-1:0] sdata,
                        input logic wen, input logic [RW-1:0] wa);
    valid_in          = 1'b1;
    mem_en_in         = memen;
    mem_we_in         = we;
    mem_size_in       = sz;
    mem_unsigned_in   = uns;
    result_in         = res;
    store_data_in     = sdata;
    write_reg_en_in   = wen;
    write_reg_addr_in = wa;
  endtask

  task automatic push(input logic [DW-1:0] r, input logic w, input logic [RW-1:0] a, input logic e);
    wb_t x;
    x.result = r; x.wen = w; x.waddr = a; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic alu_op(input string tag, input logic [DW-1:0] res, input logic [RW-1:0] wa);
    cur = tag;
    set_ex(1'b0, 1'b0, 2'd0, 1'b0, res, '0, 1'b1, wa);
    push(res, 1'b1, wa, 1'b0);
    #1;
    chk("alu_stall", DW'(stall_out), '0);
    chk("alu_req", DW'(bus.mem_req), '0);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic mem_op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [DW-1:0] addr, input logic [DW-1:0] sdata, input logic [RW-1:0] wa,
                        input int gnt_dly, input int rv_dly, input logic [DW-1:0] rdata,
                        input logic [3:0] exp_be, input logic [DW-1:0] exp_wdata,
                        input logic [DW-1:0] exp_res);
    cur = tag;
    set_ex(1'b1, we, sz, uns, addr, sdata, ~we, wa);
    for (int i = 0; i < gnt_dly; i++) begin
      #1;
      chk("req_before_gnt", DW'(bus.mem_req), 32'd1);
      chk("stall_before_gnt", DW'(stall_out), 32'd1);
      @(negedge clk);
    end
    bus.mem_gnt = 1'b1;
    #1;
    chk("req", DW'(bus.mem_req), 32'd1);
    chk("we", DW'(bus.mem_we), DW'(we));
    chk("addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
    chk("be", DW'(bus.mem_be), DW'(exp_be));
    chk("wdata", bus.mem_wdata, exp_wdata);
    chk("stall_gnt", DW'(stall_out), 32'd1);
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < rv_dly; i++) begin
      #1;
      chk("req_in_wait", DW'(bus.mem_req), '0);
      chk("stall_in_wait", DW'(stall_out), 32'd1);
      @(negedge clk);
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    push(exp_res, ~we, wa, 1'b0);
    #1;
    chk("stall_rvalid", DW'(stall_out), '0);
    chk("req_rvalid", DW'(bus.mem_req), '0);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    valid_in       = 1'b0;
  endtask

  task automatic mis_op(input string tag, input logic we, input logic [1:0] sz,
                        input logic [DW-1:0] addr, input logic [RW-1:0] wa);
    cur = tag;
    set_ex(1'b1, we, sz, 1'b0, addr, 32'h5555_AAAA, 1'b1, wa);
    push(addr, 1'b0, wa, 1'b1);
    #1;
    chk("mis_req", DW'(bus.mem_req), '0);
    chk("mis_stall", DW'(stall_out), '0);
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    chk("mis_req_after", DW'(bus.mem_req), '0);
  endtask

  initial begin
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    // Reset held while inputs toggle randomly.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid_in        = 1'($urandom);
      mem_en_in       = 1'($urandom);
      mem_we_in       = 1'($urandom);
      mem_size_in     = 2'($urandom);
      result_in       = $urandom & 32'hFFFF_FFFC;
      store_data_in   = $urandom;
      write_reg_en_in = 1'($urandom);
      bus.mem_gnt     = 1'($urandom);
      bus.mem_rvalid  = 1'($urandom);
      bus.mem_rdata   = $urandom;
      #1;
      chk("rst_req", DW'(bus.mem_req), '0);
      chk("rst_we", DW'(bus.mem_we), '0);
      chk("rst_be", DW'(bus.mem_be), '0);
      chk("rst_addr", bus.mem_addr, '0);
      chk("rst_wdata", bus.mem_wdata, '0);
      chk("rst_stall", DW'(stall_out), '0);
      chk("rst_valid", DW'(valid_out), '0);
    end
    @(negedge clk);
    valid_in = 1'b0; mem_en_in = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    rst = 1'b1;
    @(negedge clk);

    alu_op("alu", 32'h1234_5678, 5'd5);
    @(negedge clk);

    // LB / LBU from lane 3, slow then fast bus, back to back.
    mem_op("lb",  1'b0, 2'd0, 1'b0, 32'h1003, '0, 5'd7, 2, 3, 32'h8000_0000, 4'b1000, '0, 32'hFFFF_FF80);
    mem_op("lbu", 1'b0, 2'd0, 1'b1, 32'h1003, '0, 5'd8, 0, 0, 32'h8000_0000, 4'b1000, '0, 32'h0000_0080);
    mem_op("sh",  1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 5'd9, 1, 1, 32'hFFFF_FFFF,
           4'b1100, 32'hABCD_0000, 32'h2002);
    mem_op("lh",  1'b0, 2'd1, 1'b0, 32'h0102, '0, 5'd10, 0, 1, 32'h8001_0000, 4'b1100, '0, 32'hFFFF_8001);
    mem_op("lhu", 1'b0, 2'd1, 1'b1, 32'h0102, '0, 5'd11, 0, 0, 32'h8001_0000, 4'b1100, '0, 32'h0000_8001);
    mem_op("lw",  1'b0, 2'd2, 1'b0, 32'h0040, '0, 5'd12, 0, 0, 32'hDEAD_BEEF, 4'b1111, '0, 32'hDEAD_BEEF);
    mem_op("sb",  1'b1, 2'd0, 1'b0, 32'h0041, 32'h0000_0077, 5'd1, 0, 0, '0, 4'b0010, 32'h0000_7700, 32'h0041);
    @(negedge clk);

    mis_op("mis_lw", 1'b0, 2'd2, 32'h3001, 5'd13);
    @(negedge clk);
    mis_op("mis_lh", 1'b0, 2'd1, 32'h3005, 5'd14);
    mis_op("mis_sz3", 1'b1, 2'd3, 32'h3000, 5'd15);
    @(negedge clk);

    // Reset while waiting for the response; a late rvalid must be dropped.
    cur = "rst_wait";
    set_ex(1'b1, 1'b0, 2'd2, 1'b0, 32'h0080, '0, 1'b1, 5'd16);
    bus.mem_gnt = 1'b1;
    #1;
    chk("req", DW'(bus.mem_req), 32'd1);
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    #1;
    chk("stall_wait", DW'(stall_out), 32'd1);
    rst = 1'b0;
    #1;
    chk("stall_in_rst", DW'(stall_out), '0);
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_2222;
    #1;
    chk("late_rvalid_stall", DW'(stall_out), '0);
    chk("late_rvalid_req", DW'(bus.mem_req), '0);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    @(negedge clk);

    alu_op("alu_after_rst", 32'hCAFE_F00D, 5'd3);
    @(negedge clk);
    @(negedge clk);
    cur = "end";
    chk("queue_empty", DW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
